clock_heartbeat_gen: RTL and testbench



---
 rtl/clock_heartbeat_gen_pkg.sv | 29 ++
 rtl/clock_heartbeat_gen_phase_timer.sv | 57 +++++
 rtl/clock_heartbeat_gen.sv | 157 +++++++++++++++
 tb/tb_clock_heartbeat_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_heartbeat_gen_pkg.sv
// Shared types and constants for the heartbeat generator: FSM states,
// fault-injection mode codes and the default counter field width.
package clock_heartbeat_gen_pkg;

  localparam int P_CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_ARMED  = 2'd2,
    ST_INJECT = 2'd3
  } hb_state_e;

  localparam logic [1:0] MODE_NONE      = 2'b00;
  localparam logic [1:0] MODE_STUCK_HI  = 2'b01;
  localparam logic [1:0] MODE_STUCK_LO  = 2'b10;
  localparam logic [1:0] MODE_HALF_RATE = 2'b11;

  // Heartbeat level for an injected phase: forced for the stuck modes,
  // a normal toggle for half-rate.
  function automatic logic inject_level(input logic [1:0] mode, input logic current);
    case (mode)
      MODE_STUCK_HI: inject_level = 1'b1;
      MODE_STUCK_LO: inject_level = 1'b0;
      default:       inject_level = ~current;
    endcase
  endfunction

endpackage

// File: rtl/clock_heartbeat_gen_phase_timer.sv
// Phase timer: loads a phase length T, counts 0..T-1 and raises a
// registered tick on the last cycle of the phase.
module heartbeat_phase_timer
  import clock_heartbeat_gen_pkg::*;
#(
  parameter int P_CNT_W = P_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [P_CNT_W+1:0]   period_in,
  output logic                 tick
);

  localparam int TW = P_CNT_W + 2;
  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] period_q, period_d;
  logic          tick_q, tick_d;

  // Next count: clear wins, a load restarts at 0 with the new length,
  // otherwise advance; tick is precomputed so it lands on count T-1.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    if (clear) begin
      cnt_d    = '0;
      period_d = '0;
    end else if (load) begin
      cnt_d    = '0;
      period_d = period_in;
      tick_d   = (period_in == ONE);
    end else begin
      cnt_d    = cnt_q + ONE;
      tick_d   = ((cnt_q + ONE) == (period_q - ONE));
    end
  end

  // Counter, latched length and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clock_heartbeat_gen.sv
// Heartbeat generator: produces a divided test clock with programmable
// half-period and phase-aligned fault injection (stuck-high, stuck-low,
// half-rate). All outputs come straight from flops.
module clock_heartbeat_gen
  import clock_heartbeat_gen_pkg::*;
#(
  parameter int P_CNT_W = P_CNT_W_DEFAULT
) (
  input  logic               I_clock,
  input  logic               I_reset_n,
  input  logic               I_enable,
  input  logic [P_CNT_W-1:0] I_half_period,
  input  logic               I_inject_start,
  input  logic [1:0]         I_inject_mode,
  input  logic [P_CNT_W-1:0] I_inject_len,
  output logic               O_heartbeat,
  output logic               O_phase_tick,
  output logic               O_inject_busy,
  output logic               O_inject_done
);

  localparam int TW = P_CNT_W + 2;

  hb_state_e          state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [P_CNT_W-1:0] len_q, len_d;
  logic [P_CNT_W-1:0] inj_cnt_q, inj_cnt_d;
  logic               heartbeat_q, heartbeat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               timer_clear;
  logic               timer_load;
  logic [TW-1:0]      timer_period;
  logic               phase_tick;
  logic [TW-1:0]      normal_len;
  logic [TW-1:0]      half_rate_len;

  // A phase lasts N+1 cycles, or twice that while half-rate is injected.
  assign normal_len    = {2'b00, I_half_period} + TW'(1);
  assign half_rate_len = {normal_len[TW-2:0], 1'b0};

  heartbeat_phase_timer #(
    .P_CNT_W (P_CNT_W)
  ) u_timer (
    .clk       (I_clock),
    .rst_n     (I_reset_n),
    .clear     (timer_clear),
    .load      (timer_load),
    .period_in (timer_period),
    .tick      (phase_tick)
  );

  // FSM next state, heartbeat level and phase loads. A request seen in RUN
  // (even on a tick cycle) always waits in ARMED for the following boundary.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    inj_cnt_d    = inj_cnt_q;
    heartbeat_d  = heartbeat_q;
    done_d       = 1'b0;
    timer_clear  = 1'b0;
    timer_load   = 1'b0;
    timer_period = normal_len;

    if (!I_enable) begin
      state_d     = ST_IDLE;
      mode_d      = MODE_NONE;
      len_d       = '0;
      inj_cnt_d   = '0;
      heartbeat_d = 1'b0;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_RUN;
          heartbeat_d = 1'b1;
          timer_load  = 1'b1;
        end
        ST_RUN: begin
          if (phase_tick) begin
            heartbeat_d = ~heartbeat_q;
            timer_load  = 1'b1;
          end
          if (I_inject_start && (I_inject_mode != MODE_NONE)) begin
            state_d = ST_ARMED;
            mode_d  = I_inject_mode;
            len_d   = I_inject_len;
          end
        end
        ST_ARMED: begin
          if (phase_tick) begin
            state_d     = ST_INJECT;
            inj_cnt_d   = '0;
            heartbeat_d = inject_level(mode_q, heartbeat_q);
            timer_load  = 1'b1;
            if (mode_q == MODE_HALF_RATE) begin
              timer_period = half_rate_len;
            end
          end
        end
        ST_INJECT: begin
          if (phase_tick) begin
            timer_load = 1'b1;
            if (inj_cnt_q == len_q) begin
              state_d     = ST_RUN;
              heartbeat_d = ~heartbeat_q;
              done_d      = 1'b1;
              mode_d      = MODE_NONE;
              len_d       = '0;
              inj_cnt_d   = '0;
            end else begin
              inj_cnt_d   = inj_cnt_q + 1'b1;
              heartbeat_d = inject_level(mode_q, heartbeat_q);
              if (mode_q == MODE_HALF_RATE) begin
                timer_period = half_rate_len;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_INJECT);
  end

  // State, latched injection fields and registered outputs.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      len_q       <= '0;
      inj_cnt_q   <= '0;
      heartbeat_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      inj_cnt_q   <= inj_cnt_d;
      heartbeat_q <= heartbeat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign O_heartbeat   = heartbeat_q;
  assign O_phase_tick  = phase_tick;
  assign O_inject_busy = busy_q;
  assign O_inject_done = done_q;

endmodule

// File: tb/tb_clock_heartbeat_gen.sv
// Testbench for clock_heartbeat_gen: directed scenarios plus randomized
// traffic, scored cycle by cycle against a phase-level reference model.
module tb_clock_heartbeat_gen;

  localparam int CW = 5;

  typedef struct packed {
    logic hb;
    logic tick;
    logic busy;
    logic done;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [CW-1:0] half_period;
  logic          inject_start;
  logic [1:0]    inject_mode;
  logic [CW-1:0] inject_len;
  logic          heartbeat;
  logic          phase_tick;
  logic          inject_busy;
  logic          inject_done;

  int   checks;
  int   errors;
  int   cycle_no;
  int   loss_cycles;
  int   chk_n;
  exp_t exp_q[$];

  // Reference model state, expressed as whole phases rather than counters.
  bit m_active;
  bit m_level;
  int m_left;
  bit m_pend;
  int m_pend_mode;
  int m_pend_len;
  int m_inj_left;
  int m_inj_mode;

  clock_heartbeat_gen #(.P_CNT_W(CW)) dut (
    .I_clock        (clock),
    .I_reset_n      (reset_n),
    .I_enable       (enable),
    .I_half_period  (half_period),
    .I_inject_start (inject_start),
    .I_inject_mode  (inject_mode),
    .I_inject_len   (inject_len),
    .O_heartbeat    (heartbeat),
    .O_phase_tick   (phase_tick),
    .O_inject_busy  (inject_busy),
    .O_inject_done  (inject_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0b required %0b", name, actual, expected);
    end
  endtask

  // Sets the level for a new injected phase and returns its length.
  function automatic int injected_phase(input int n);
    if (m_inj_mode == 1) m_level = 1'b1;
    else if (m_inj_mode == 2) m_level = 1'b0;
    else m_level = !m_level;
    return (m_inj_mode == 3) ? 2 * (n + 1) : n + 1;
  endfunction

  // One clock of the reference model; pushes the outputs expected after the edge.
  function automatic void model_step(input bit en, input int n, input bit start,
                                     input int mode, input int len);
    bit   done_now;
    bit   accept;
    int   plen;
    exp_t e;
    done_now = 1'b0;
    if (!en) begin
      m_active = 0; m_level = 0; m_left = 0; m_pend = 0; m_inj_left = 0;
    end else if (!m_active) begin
      m_active = 1; m_level = 1; m_left = n + 1;
    end else begin
      accept = start && (mode != 0) && !m_pend && (m_inj_left == 0);
      if (m_left == 1) begin
        plen = n + 1;
        if (m_inj_left > 0) begin
          m_inj_left--;
          if (m_inj_left == 0) begin
            done_now = 1'b1;
            m_level  = !m_level;
          end else begin
            plen = injected_phase(n);
          end
        end else if (m_pend) begin
          m_pend     = 0;
          m_inj_mode = m_pend_mode;
          m_inj_left = m_pend_len + 1;
          plen       = injected_phase(n);
        end else begin
          m_level = !m_level;
        end
        m_left = plen;
      end else begin
        m_left--;
      end
      if (accept) begin
        m_pend = 1; m_pend_mode = mode; m_pend_len = len;
      end
    end
    e.hb   = m_active && m_level;
    e.tick = m_active && (m_left == 1);
    e.busy = (m_inj_left > 0);
    e.done = done_now;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input bit en, input int n, input bit start,
                               input int mode, input int len);
    @(negedge clock);
    enable       = en;
    half_period  = CW'(n);
    inject_start = start;
    inject_mode  = 2'(mode);
    inject_len   = CW'(len);
    model_step(en, n, start, mode, len);
  endtask

  task automatic runCycles(input int count, input bit en, input int n);
    repeat (count) applyStimulus(en, n, 1'b0, 0, 0);
  endtask

  // Monitor: every clock with an outstanding expectation, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && (exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("cycle %0d hb/tick/busy/done", cycle_no),
                    {heartbeat, phase_tick, inject_busy, inject_done}, e);
        cycle_no++;
      end
    end
  end

  // Clock-loss watcher: counts cycles where the heartbeat has held one level
  // longer than the longest legal phase, 2*(N+1).
  initial begin
    logic prev_hb;
    int   run_len;
    prev_hb = 1'b0;
    run_len = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n || !enable) begin
        run_len = 0;
      end else begin
        if (heartbeat != prev_hb) run_len = 1;
        else run_len++;
        if (run_len > 2 * (chk_n + 1)) loss_cycles++;
      end
      prev_hb = heartbeat;
    end
  end

  initial begin
    int loss_before;
    int cur_n;
    bit r_en;
    bit r_start;
    int r_mode;
    int r_len;

    checks = 0; errors = 0; cycle_no = 0; loss_cycles = 0; chk_n = 3;
    reset_n = 1'b0; enable = 1'b0; half_period = '0;
    inject_start = 1'b0; inject_mode = 2'b00; inject_len = '0;

    // Outputs held at zero throughout reset, even with enable requested.
    #12;
    checkOutput("reset outputs", {heartbeat, phase_tick, inject_busy, inject_done}, 0);
    enable = 1'b1;
    #20;
    checkOutput("reset outputs with enable", {heartbeat, phase_tick, inject_busy, inject_done}, 0);
    @(negedge clock);
    enable  = 1'b0;
    reset_n = 1'b1;
    $display("[TB] reset released");

    runCycles(3, 1'b0, 3);

    // Plain N=3 heartbeat.
    runCycles(40, 1'b1, 3);

    // Stuck-high L=2 requested mid-phase, with ignored repeat requests.
    runCycles(1, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 1, 2);
    runCycles(1, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 2, 0);
    runCycles(6, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 3, 5);
    runCycles(20, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 0, 7);
    runCycles(12, 1'b1, 3);

    // Half-rate N=1 L=0.
    runCycles(6, 1'b1, 1);
    applyStimulus(1'b1, 1, 1'b1, 3, 0);
    runCycles(16, 1'b1, 1);

    // Enable dropped during an active injection.
    applyStimulus(1'b1, 2, 1'b1, 2, 5);
    runCycles(10, 1'b1, 2);
    runCycles(3, 1'b0, 2);
    runCycles(10, 1'b1, 2);

    // N=0 with the longest injection length.
    runCycles(8, 1'b1, 0);
    applyStimulus(1'b1, 0, 1'b1, 3, 31);
    runCycles(75, 1'b1, 0);

    // N=31.
    runCycles(80, 1'b1, 31);

    // Clock-loss watcher: silent for normal and half-rate, firing when stuck.
    runCycles(40, 1'b1, 3);
    loss_before = loss_cycles;
    runCycles(10, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 3, 3);
    runCycles(50, 1'b1, 3);
    checkOutput("loss flag during half-rate", loss_cycles - loss_before, 0);
    loss_before = loss_cycles;
    applyStimulus(1'b1, 3, 1'b1, 1, 3);
    runCycles(30, 1'b1, 3);
    checkOutput("loss flag during stuck-high", (loss_cycles > loss_before) ? 1 : 0, 1);
    loss_before = loss_cycles;
    runCycles(10, 1'b1, 3);
    applyStimulus(1'b1, 3, 1'b1, 2, 3);
    runCycles(30, 1'b1, 3);
    checkOutput("loss flag during stuck-low", (loss_cycles > loss_before) ? 1 : 0, 1);

    // Randomized traffic.
    cur_n = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)
        cur_n = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 6));
      r_en    = ($urandom_range(0, 99) != 0);
      r_start = ($urandom_range(0, 9) == 0);
      r_mode  = $urandom_range(0, 3);
      r_len   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                             : int'($urandom_range(0, 3));
      applyStimulus(r_en, cur_n, r_start, r_mode, r_len);
    end
    runCycles(12, 1'b1, 2);

    // Let the monitor consume everything that is still expected.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
      #2;
    end
    checkOutput("scoreboard drained", exp_q.size(), 0);

    // Asynchronous reset mid-cycle clears the outputs immediately.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset outputs", {heartbeat, phase_tick, inject_busy, inject_done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
